// File: rtl/atpg_pattern_sequencer.sv
// Drives LFSR-generated patterns into a combinational circuit under test and
// compacts the captured response bits into a 16-bit signature.
module atpg_pattern_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        start,
  input  logic        abort,
  input  logic [12:0] seed,
  input  logic [15:0] num_pat,
  input  logic        cut_out,
  output logic [12:0] pat,
  output logic        cut_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] sig,
  output logic [15:0] ones_cnt,
  output logic [15:0] pat_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state, state_nx;
  logic [3:0]  settle_cnt, settle_cnt_nx;
  logic [15:0] num_lat, num_lat_nx;
  logic [12:0] pat_nx;
  logic [15:0] sig_nx, ones_nx, idx_nx;
  logic        busy_nx;

  logic        fb;
  logic [12:0] pat_step;
  logic [16:0] idx_inc;

  // Signature feedback x^16+x^14+x^13+x^11+1 with the response bit folded in.
  assign fb       = sig[15] ^ sig[13] ^ sig[12] ^ sig[10] ^ cut_out;
  assign pat_step = {pat[11:0], pat[12] ^ pat[3] ^ pat[2] ^ pat[0]};
  assign idx_inc  = {1'b0, pat_idx} + 17'd1;

  always_comb begin
    // NOTE: every next-value starts at its current value, so no branch of the case can infer a latch.
    state_nx      = state;
    settle_cnt_nx = settle_cnt;
    num_lat_nx    = num_lat;
    pat_nx        = pat;
    sig_nx        = sig;
    ones_nx       = ones_cnt;
    idx_nx        = pat_idx;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          sig_nx  = '0;
          ones_nx = '0;
          idx_nx  = '0;
          if (num_pat != 16'd0) begin
            state_nx   = S_APPLY;
            pat_nx     = (seed == 13'd0) ? 13'd1 : seed;
            num_lat_nx = num_pat;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else begin
          state_nx      = S_SETTLE;
          settle_cnt_nx = SETTLE_LAST;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (settle_cnt == 4'd0) begin
          state_nx = S_CAPTURE;
        end else begin
          settle_cnt_nx = settle_cnt - 4'd1;
        end
      end
      S_CAPTURE: begin
        // Abort wins: the response of an aborted capture is discarded.
        if (abort) begin
          state_nx = S_IDLE;
        end else begin
          sig_nx  = {sig[14:0], fb};
          ones_nx = ones_cnt + {15'd0, cut_out};
          if (idx_inc < {1'b0, num_lat}) begin
            idx_nx   = idx_inc[15:0];
            pat_nx   = pat_step;
            state_nx = S_APPLY;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    busy_nx = (state_nx == S_APPLY) || (state_nx == S_SETTLE) || (state_nx == S_CAPTURE);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      num_lat    <= '0;
      pat        <= '0;
      sig        <= '0;
      ones_cnt   <= '0;
      pat_idx    <= '0;
      busy       <= 1'b0;
      cut_en     <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees only pre-edge values.
      state      <= state_nx;
      settle_cnt <= settle_cnt_nx;
      num_lat    <= num_lat_nx;
      pat        <= pat_nx;
      sig        <= sig_nx;
      ones_cnt   <= ones_nx;
      pat_idx    <= idx_nx;
      busy       <= busy_nx;
      cut_en     <= busy_nx;
      done       <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_atpg_pattern_sequencer.sv
// Directed bench for atpg_pattern_sequencer: a run-level model predicts every
// output from elapsed cycles since start; literal checks pin known results.
module tb_atpg_pattern_sequencer;

  localparam int SETTLE_TB = 2;
  localparam int P         = SETTLE_TB + 2;   // cycles per pattern

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [12:0] seed = '0;
  logic [15:0] num_pat = '0;
  logic        cut_out;
  logic [12:0] pat;
  logic        cut_en, busy, done;
  logic [15:0] sig, ones_cnt, pat_idx;

  // The CUT: parity of the masked pattern, optionally inverted.
  logic [12:0] cut_mask = '0;
  logic        cut_inv  = 1'b0;
  assign cut_out = (^(pat & cut_mask)) ^ cut_inv;

  atpg_pattern_sequencer #(.SETTLE(SETTLE_TB)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .abort(abort), .seed(seed),
    .num_pat(num_pat), .cut_out(cut_out), .pat(pat), .cut_en(cut_en),
    .busy(busy), .done(done), .sig(sig), .ones_cnt(ones_cnt), .pat_idx(pat_idx)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- run-level model ----------------
  // mode: 0 idle, 1 running, 2 done cycle
  int          m_mode = 0, m_t = 0, m_n = 0;
  logic [12:0] mp [64];
  logic [15:0] msig [64];
  logic [15:0] mones [64];
  logic [15:0] m_s, m_o;
  logic        m_cb;
  logic [12:0] e_pat = '0;
  logic [15:0] e_sig = '0, e_ones = '0, e_idx = '0;
  logic        e_busy = 1'b0, e_cut = 1'b0, e_done = 1'b0;

  task automatic eval_at(input int t);
    int c;
    c = t / P;
    if (t < m_n * P) begin
      e_busy = 1'b1; e_cut = 1'b1; e_done = 1'b0;
      e_pat = mp[c]; e_idx = 16'(c); e_sig = msig[c]; e_ones = mones[c];
    end else begin
      e_busy = 1'b0; e_cut = 1'b0; e_done = 1'b1;
      e_pat = mp[m_n-1]; e_idx = 16'(m_n-1); e_sig = msig[m_n]; e_ones = mones[m_n];
    end
  endtask

  always @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      m_mode = 0; e_pat = '0; e_sig = '0; e_ones = '0; e_idx = '0;
      e_busy = 1'b0; e_cut = 1'b0; e_done = 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_n = int'(num_pat);
          mp[0] = (seed == 13'd0) ? 13'd1 : seed;
          m_s = '0; m_o = '0; msig[0] = '0; mones[0] = '0;
          for (int i = 0; i < m_n && i < 63; i++) begin
            if (i > 0) mp[i] = {mp[i-1][11:0], mp[i-1][12] ^ mp[i-1][3] ^ mp[i-1][2] ^ mp[i-1][0]};
            m_cb = (^(mp[i] & cut_mask)) ^ cut_inv;
            m_s = {m_s[14:0], m_s[15] ^ m_s[13] ^ m_s[12] ^ m_s[10] ^ m_cb};
            m_o = m_o + {15'd0, m_cb};
            msig[i+1] = m_s; mones[i+1] = m_o;
          end
          m_t = 0;
          if (m_n == 0) begin
            m_mode = 2; e_done = 1'b1; e_sig = '0; e_ones = '0; e_idx = '0;
          end else begin
            m_mode = 1; eval_at(0);
          end
        end
        1: if (abort) begin
          m_mode = 0; e_busy = 1'b0; e_cut = 1'b0;
        end else begin
          m_t++;
          eval_at(m_t);
          if (m_t == m_n * P) m_mode = 2;
        end
        default: begin
          m_mode = 0; e_done = 1'b0;
        end
      endcase
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("pat", 32'(pat), 32'(e_pat));
      check("sig", 32'(sig), 32'(e_sig));
      check("ones_cnt", 32'(ones_cnt), 32'(e_ones));
      check("pat_idx", 32'(pat_idx), 32'(e_idx));
      check("busy", 32'(busy), 32'(e_busy));
      check("cut_en", 32'(cut_en), 32'(e_cut));
      check("done", 32'(done), 32'(e_done));
    end
  end

  // ---------------- directed stimulus ----------------
  // poke > 0: pulse a spurious start at that cycle; poke_done: pulse start in DONE.
  task automatic run_test(input string tag, input logic [12:0] s, input logic [15:0] n,
                          input logic [12:0] mask, input logic inv, input int exp_cycle,
                          input logic [12:0] exp_first, input int poke, input bit poke_done);
    int k;
    @(negedge CLK);
    seed = s; num_pat = n; cut_mask = mask; cut_inv = inv; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    k = 1;
    if (n != 16'd0) check({tag, "_first_pat"}, 32'(pat), 32'(exp_first));
    while (done !== 1'b1 && k < 1000) begin
      if (k == poke) begin
        start = 1'b1; num_pat = 16'd0; seed = 13'h1555;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      k++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(k), 32'(exp_cycle));
    if (poke_done) begin
      num_pat = 16'd3; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      check({tag, "_start_in_done_ignored"}, 32'(busy), 32'd0);
    end
  endtask

  bit saw_done;

  initial begin
    #1 CLR = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_pat", 32'(pat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sig", 32'(sig), 32'd0);
    check("rst_cut_en", 32'(cut_en), 32'd0);
    cmp_en = 1'b1;
    #2 CLR = 1'b1;
    repeat (2) @(negedge CLK);

    run_test("r1", 13'h0001, 16'd1, 13'h0000, 1'b1, 5, 13'h0001, 0, 1'b0);
    check("r1_sig", 32'(sig), 32'h0001);
    check("r1_ones", 32'(ones_cnt), 32'd1);
    check("r1_idx", 32'(pat_idx), 32'd0);

    run_test("r2", 13'h0001, 16'd2, 13'h0000, 1'b1, 9, 13'h0001, 0, 1'b0);
    check("r2_pat", 32'(pat), 32'h0003);
    check("r2_sig", 32'(sig), 32'h0003);
    check("r2_ones", 32'(ones_cnt), 32'd2);
    check("r2_idx", 32'(pat_idx), 32'd1);

    run_test("r3", 13'h0000, 16'd3, 13'h0000, 1'b0, 13, 13'h0001, 0, 1'b0);
    check("r3_pat", 32'(pat), 32'h0007);
    check("r3_sig", 32'(sig), 32'h0000);
    check("r3_ones", 32'(ones_cnt), 32'd0);

    run_test("r0", 13'h0AAA, 16'd0, 13'h0000, 1'b1, 1, 13'h0000, 0, 1'b0);
    check("r0_busy", 32'(busy), 32'd0);
    check("r0_pat_kept", 32'(pat), 32'h0007);
    check("r0_sig", 32'(sig), 32'd0);
    check("r0_ones", 32'(ones_cnt), 32'd0);

    run_test("rm", 13'h1ACE, 16'd10, 13'h0A55, 1'b0, 41, 13'h1ACE, 17, 1'b0);
    run_test("rp", 13'h1234, 16'd5, 13'h1FFF, 1'b1, 21, 13'h1234, 0, 1'b1);

    // Abort in the second SETTLE of a 4-pattern run.
    @(negedge CLK);
    seed = 13'h0001; num_pat = 16'd4; cut_mask = '0; cut_inv = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_cut_en", 32'(cut_en), 32'd0);
    check("ab_ones", 32'(ones_cnt), 32'd1);
    check("ab_idx", 32'(pat_idx), 32'd1);
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (done) saw_done = 1'b1;
    end
    check("ab_no_done", 32'(saw_done), 32'd0);

    // Abort while idle does nothing.
    abort = 1'b1;
    repeat (2) @(negedge CLK);
    abort = 1'b0;
    check("ab_idle_busy", 32'(busy), 32'd0);
    check("ab_idle_ones", 32'(ones_cnt), 32'd1);

    // Reset pulse during CAPTURE of the first pattern.
    @(negedge CLK);
    seed = 13'h0001; num_pat = 16'd2; cut_mask = '0; cut_inv = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    #2 CLR = 1'b0;
    #1;
    check("clr_pat", 32'(pat), 32'd0);
    check("clr_sig", 32'(sig), 32'd0);
    check("clr_ones", 32'(ones_cnt), 32'd0);
    check("clr_idx", 32'(pat_idx), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_cut_en", 32'(cut_en), 32'd0);
    @(negedge CLK);
    #2 CLR = 1'b1;
    repeat (3) @(negedge CLK);
    check("clr_stays_idle", 32'(busy), 32'd0);
    run_test("rr", 13'h0001, 16'd2, 13'h0000, 1'b1, 9, 13'h0001, 0, 1'b0);
    check("rr_sig", 32'(sig), 32'h0003);

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/atpg_pattern_sequencer.md
ATPG_PATTERN_SEQUENCER -- requirements
Module: atpg_pattern_sequencer

Interface
REQ-001 Parameter: SETTLE, default 2, number of settle cycles (1..15) between pattern apply and response capture.
REQ-002 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-003 Port: CLR  in  1  reset, asynchronous, active-low.
REQ-004 Port: start  in  1  begin a test run; sampled only in IDLE.
REQ-005 Port: abort  in  1  terminate the run in progress.
REQ-006 Port: seed  in  13  initial pattern; sampled with start.
REQ-007 Port: num_pat  in  16  number of patterns to apply; sampled with start.
REQ-008 Port: cut_out  in  1  response bit from the combinational circuit under test (CUT).
REQ-009 Port: pat  out  13  stimulus to CUT, bit i drives CUT input v(i).
REQ-010 Port: cut_en  out  1  drives CUT CLR gate input; 1 while a run is active.
REQ-011 Port: busy  out  1  high in APPLY, SETTLE and CAPTURE.
REQ-012 Port: done  out  1  one-cycle pulse at normal run completion.
REQ-013 Port: sig  out  16  response signature.
REQ-014 Port: ones_cnt  out  16  count of captured cut_out==1.
REQ-015 Port: pat_idx  out  16  index of the current or last captured pattern.

Function
REQ-016 FSM states: IDLE, APPLY, SETTLE, CAPTURE, DONE; state is registered; all outputs are registered.
REQ-017 IDLE & start & num_pat!=0 -> APPLY next cycle; pat<=seed (0x0001 if seed==0), sig<=0, ones_cnt<=0, pat_idx<=0, num_pat latched, cut_en<=1.
REQ-018 IDLE & start & num_pat==0 -> DONE next cycle; sig, ones_cnt, pat_idx cleared to 0; pat unchanged.
REQ-019 APPLY lasts exactly 1 cycle -> SETTLE; SETTLE lasts exactly SETTLE cycles (internal 4-bit counter) -> CAPTURE.
REQ-020 CAPTURE (1 cycle): sample cut_out; fb = sig[15]^sig[13]^sig[12]^sig[10]^cut_out; sig<={sig[14:0],fb}; ones_cnt += cut_out.
REQ-021 CAPTURE with pat_idx+1 < latched num_pat: pat_idx += 1, pat <= LFSR next of pat, -> APPLY.
REQ-022 Pattern LFSR next: {pat[11:0], pat[12]^pat[3]^pat[2]^pat[0]} (x^13+x^4+x^3+x+1, period 8191).
REQ-023 CAPTURE with pat_idx+1 == latched num_pat: pat_idx unchanged, -> DONE.
REQ-024 DONE: done=1 for exactly 1 cycle, cut_en<=0, -> IDLE; sig, ones_cnt, pat_idx, pat hold until next start.
REQ-025 Run of N>0 patterns: done high in cycle N*(SETTLE+2)+1 after the start-sampling edge.
REQ-026 pat stable throughout APPLY, SETTLE and CAPTURE of each pattern.
REQ-027 start while busy or in DONE is ignored.
REQ-028 abort in APPLY/SETTLE/CAPTURE -> IDLE next cycle, cut_en<=0, no done pulse; sig, ones_cnt, pat_idx retain last values.
REQ-029 abort has priority over CAPTURE update in the same cycle (no sig/ones_cnt update); abort in IDLE/DONE has no effect.
REQ-030 ones_cnt and pat_idx are 16-bit; num_pat max 0xFFFF cannot overflow them.

Reset
REQ-031 CLR low asynchronously forces: state IDLE, pat=0, cut_en=0, busy=0, done=0, sig=0, ones_cnt=0, pat_idx=0, settle counter 0.
REQ-032 CLR low mid-run aborts immediately; after release the block stays IDLE until start.

Verification
REQ-033 seed=0x0001, num_pat=1, SETTLE=2, cut_out=1 -> pat=0x0001, done in cycle 5, sig=0x0001, ones_cnt=1, pat_idx=0.
REQ-034 seed=0x0001, num_pat=2, cut_out=1 -> second pat=0x0003, sig=0x0003, ones_cnt=2, pat_idx=1, done in cycle 9.
REQ-035 seed=0x0000, num_pat=3, cut_out=0 -> first pat=0x0001, sig=0x0000, ones_cnt=0, done in cycle 13.
REQ-036 num_pat=0 with start -> done in cycle 1, busy never asserted, sig=0, ones_cnt=0.
REQ-037 abort asserted during second SETTLE of a 4-pattern run -> IDLE next cycle, no done, cut_en=0, ones_cnt equals first capture only.
REQ-038 CLR pulsed low during CAPTURE -> all outputs 0 immediately, no sig update; new start after release runs normally.
